// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bit positions, FSM states.
// Build option ALU_DIV_EN makes DIV/MOD iterative instead of illegal single-cycle ops.
package alu_defs;

  typedef enum logic [2:0] {
    ARITH_SUM = 3'b000,
    ARITH_RES = 3'b001,
    ARITH_MUL = 3'b010,
    CR_       = 3'b011,
    LOG_AND   = 3'b100,
    LOG_OR    = 3'b101,
    ARITH_DIV = 3'b110,
    ARITH_MOD = 3'b111
  } opcode_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_iter_op(input opcode_t op);
`ifdef ALU_DIV_EN
    return (op == ARITH_MUL) || (op == ARITH_DIV) || (op == ARITH_MOD);
`else
    return (op == ARITH_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between decode, the ALU and writeback.
// slave = ALU side, master = the driver of operands and consumer of results.
interface alu_mc_if #(
  parameter int N = 16
);
  import alu_defs::*;

  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  opcode_t      opcode_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] result_o;
  logic [3:0]   ALUFlags;

  modport slave (
    input  valid_i, a_i, b_i, opcode_i, ready_i,
    output ready_o, valid_o, result_o, ALUFlags
  );

  modport master (
    output valid_i, a_i, b_i, opcode_i, ready_i,
    input  ready_o, valid_o, result_o, ALUFlags
  );

endinterface

// File: rtl/alu_mc_iter_unit.sv
// Shared shift/count engine: shift-add multiply and, with ALU_DIV_EN, restoring divide.
// lo_o/hi_o present the outcome of the current step, so they hold the final answer while done_o is high.
module alu_iter_unit
  import alu_defs::*;
#(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic         op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] lo_o,
  output logic [N-1:0] hi_o
);

  localparam int CW = $clog2(N);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  lo_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  lo_d;
  logic [N-1:0]  hi_d;
  logic [N:0]    mul_sum;

`ifdef ALU_DIV_EN
  logic          div_q;
  logic [N:0]    rem_s;
  logic [N+1:0]  rem_diff;
`else
  logic          unused_op;
  assign unused_op = op_i;
`endif

  always_comb begin
    // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    lo_d    = {mul_sum[0], lo_q[N-1:1]};
    hi_d    = mul_sum[N:1];
`ifdef ALU_DIV_EN
    // Divide: hi is the partial remainder, lo shifts out dividend and in quotient bits.
    // The extra top bit keeps b==0 from ever borrowing, giving an all-ones quotient.
    rem_s    = {hi_q, lo_q[N-1]};
    rem_diff = {1'b0, rem_s} - {2'b00, b_q};
    if (div_q) begin
      if (!rem_diff[N+1]) begin
        hi_d = rem_diff[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b1};
      end else begin
        hi_d = rem_s[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b0};
      end
    end
`endif
  end

  assign done_o = run_q && (cnt_q == CW'(N - 1));
  assign lo_o   = lo_d;
  assign hi_o   = hi_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      lo_q  <= a_i;
      hi_q  <= '0;
      b_q   <= b_i;
`ifdef ALU_DIV_EN
      div_q <= op_i;
`endif
    end else if (run_q) begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: one op per handshake, registered result and Z/N/C/V flags.
// ALU_DIV_EN selects an iterative divider for DIV/MOD; otherwise they return an illegal-op result.
module alu_mc
  import alu_defs::*;
#(
  parameter int N = 16
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  alu_mc_if.slave   bus
);

  state_t       state_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  opcode_t      op_q;
`ifdef ALU_DIV_EN
  logic         div0_q;
`endif

  logic         accept;
  logic         start;
  logic [N:0]   sum_w;
  logic [N-1:0] diff_w;
  logic [N-1:0] s_res;
  logic         s_c;
  logic         s_v;
  logic [N-1:0] i_res;
  logic         i_c;
  logic         i_v;
  logic         iter_done;
  logic [N-1:0] iter_lo;
  logic [N-1:0] iter_hi;

  function automatic logic [3:0] pack_flags(input logic [N-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[N-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign bus.ready_o  = rst_n_i && ((state_q == IDLE) || ((state_q == DONE) && bus.ready_i));
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = result_q;
  assign bus.ALUFlags = flags_q;

  assign accept = bus.valid_i && bus.ready_o;
  assign start  = accept && is_iter_op(bus.opcode_i);

  alu_iter_unit #(.N(N)) u_iter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start),
    .op_i    (bus.opcode_i != ARITH_MUL),
    .a_i     (bus.a_i),
    .b_i     (bus.b_i),
    .done_o  (iter_done),
    .lo_o    (iter_lo),
    .hi_o    (iter_hi)
  );

  always_comb begin
    sum_w  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    diff_w = bus.a_i - bus.b_i;
    s_res  = '0;
    s_c    = 1'b0;
    s_v    = 1'b0;
    case (bus.opcode_i)
      ARITH_SUM: begin
        s_res = sum_w[N-1:0];
        s_c   = sum_w[N];
        s_v   = (bus.a_i[N-1] == bus.b_i[N-1]) && (sum_w[N-1] != bus.a_i[N-1]);
      end
      ARITH_RES: begin
        s_res = diff_w;
        s_c   = (bus.a_i < bus.b_i);
        s_v   = (bus.a_i[N-1] != bus.b_i[N-1]) && (diff_w[N-1] != bus.a_i[N-1]);
      end
      CR_:     s_res = bus.b_i;
      LOG_AND: s_res = bus.a_i & bus.b_i;
      LOG_OR:  s_res = bus.a_i | bus.b_i;
`ifndef ALU_DIV_EN
      ARITH_DIV, ARITH_MOD: s_v = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    i_res = iter_lo;
    i_c   = 1'b0;
    i_v   = 1'b0;
    case (op_q)
      ARITH_MUL: i_c = |iter_hi;
`ifdef ALU_DIV_EN
      ARITH_DIV: i_v = div0_q;
      ARITH_MOD: begin
        i_res = iter_hi;
        i_v   = div0_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      op_q     <= ARITH_SUM;
`ifdef ALU_DIV_EN
      div0_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (start) begin
              state_q <= BUSY;
              op_q    <= bus.opcode_i;
`ifdef ALU_DIV_EN
              div0_q  <= (bus.b_i == '0);
`endif
            end else begin
              state_q  <= DONE;
              result_q <= s_res;
              flags_q  <= pack_flags(s_res, s_c, s_v);
            end
          end else if ((state_q == DONE) && bus.ready_i) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state_q  <= DONE;
            result_q <= i_res;
            flags_q  <= pack_flags(i_res, i_c, i_v);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (N=16); DIV/MOD expectations follow ALU_DIV_EN.
module tb_alu_mc;
  import alu_defs::*;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_mc_if #(.N(16)) bus ();

  alu_mc #(.N(16)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input opcode_t op, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    bus.opcode_i = op;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.valid_i  = 1'b1;
    while (!bus.ready_o && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("accept_wait_in_bounds", 32'(guard < 50), 32'd1);
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    bus.a_i     = 16'hDEAD;
    bus.b_i     = 16'hBEEF;
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic [15:0] exp_res,
                             input logic [3:0] exp_flags, input int cyc0);
    int cyc = cyc0;
    while (!bus.valid_o && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_result"}, 32'(bus.result_o), 32'(exp_res));
    chk({tag, "_flags"}, 32'(bus.ALUFlags), 32'(exp_flags));
  endtask

  task automatic consume(input string tag);
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.ready_i = 1'b0;
    chk({tag, "_valid_cleared"}, 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    int cyc;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.opcode_i = ARITH_SUM;

    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_result", 32'(bus.result_o), 32'd0);
    chk("rst_flags", 32'(bus.ALUFlags), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    #1 chk("rst_release_ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk_i); #1;

    issue(ARITH_SUM, 16'h7FFF, 16'h0001);
    wait_result("sum_ovf", 1, 16'h8000, 4'b1010, 1);
    consume("sum_ovf");

    issue(ARITH_SUM, 16'hFFFF, 16'h0001);
    wait_result("sum_carry", 1, 16'h0000, 4'b0101, 1);
    consume("sum_carry");

    issue(ARITH_RES, 16'd3, 16'd5);
    wait_result("res_borrow", 1, 16'hFFFE, 4'b0110, 1);
    consume("res_borrow");

    issue(ARITH_MUL, 16'h0100, 16'h0100);
    wait_result("mul_wrap", 17, 16'h0000, 4'b0101, 1);
    consume("mul_wrap");

    issue(ARITH_MUL, 16'd7, 16'd6);
    wait_result("mul_7x6", 17, 16'd42, 4'b0000, 1);
    consume("mul_7x6");

    issue(LOG_OR, 16'h00F0, 16'h0F00);
    wait_result("log_or", 1, 16'h0FF0, 4'b0000, 1);
    consume("log_or");

    issue(CR_, 16'h1234, 16'h8001);
    wait_result("cr_mov", 1, 16'h8001, 4'b0010, 1);
    consume("cr_mov");

    // Hold the result under backpressure, then take it and a new op on the same edge.
    issue(LOG_AND, 16'hF0F0, 16'h3C3C);
    wait_result("log_and", 1, 16'h3030, 4'b0000, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("bp_valid", 32'(bus.valid_o), 32'd1);
      chk("bp_result", 32'(bus.result_o), 32'h3030);
      chk("bp_flags", 32'(bus.ALUFlags), 32'd0);
      chk("bp_ready", 32'(bus.ready_o), 32'd0);
    end
    bus.opcode_i = ARITH_SUM;
    bus.a_i      = 16'd1;
    bus.b_i      = 16'd2;
    bus.valid_i  = 1'b1;
    bus.ready_i  = 1'b1;
    #1 chk("b2b_ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("b2b_valid", 32'(bus.valid_o), 32'd1);
    chk("b2b_result", 32'(bus.result_o), 32'd3);
    chk("b2b_flags", 32'(bus.ALUFlags), 32'd0);
    consume("b2b");

    // Offers made while the multiplier is busy must be ignored.
    issue(ARITH_MUL, 16'd3, 16'd5);
    cyc = 1;
    for (int i = 0; i < 6; i++) begin
      bus.opcode_i = ARITH_SUM;
      bus.a_i      = 16'd9;
      bus.b_i      = 16'd9;
      bus.valid_i  = 1'b1;
      #1 chk("busy_ready", 32'(bus.ready_o), 32'd0);
      @(posedge clk_i); #1;
      bus.valid_i = 1'b0;
      cyc++;
    end
    wait_result("busy_mul", 17, 16'd15, 4'b0000, cyc);
    consume("busy_mul");
    @(posedge clk_i); #1;
    chk("busy_no_extra", 32'(bus.valid_o), 32'd0);

    // Abort a multiply with reset at cycle 5.
    issue(ARITH_MUL, 16'h1234, 16'd2);
    repeat (4) @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.valid_o), 32'd0);
    chk("abort_result", 32'(bus.result_o), 32'd0);
    chk("abort_flags", 32'(bus.ALUFlags), 32'd0);
    chk("abort_ready", 32'(bus.ready_o), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    #1 chk("abort_release_ready", 32'(bus.ready_o), 32'd1);
    repeat (20) begin
      @(posedge clk_i); #1;
      chk("abort_no_output", 32'(bus.valid_o), 32'd0);
    end

    issue(ARITH_MUL, 16'd7, 16'd6);
    wait_result("mul_after_abort", 17, 16'd42, 4'b0000, 1);
    consume("mul_after_abort");

`ifdef ALU_DIV_EN
    issue(ARITH_DIV, 16'd100, 16'd7);
    wait_result("div_100_7", 17, 16'd14, 4'b0000, 1);
    consume("div_100_7");
    issue(ARITH_MOD, 16'd100, 16'd7);
    wait_result("mod_100_7", 17, 16'd2, 4'b0000, 1);
    consume("mod_100_7");
    issue(ARITH_DIV, 16'd5, 16'd0);
    wait_result("div_by_0", 17, 16'hFFFF, 4'b1010, 1);
    consume("div_by_0");
    issue(ARITH_MOD, 16'd5, 16'd0);
    wait_result("mod_by_0", 17, 16'd5, 4'b1000, 1);
    consume("mod_by_0");
`else
    issue(ARITH_DIV, 16'd100, 16'd7);
    wait_result("div_illegal", 1, 16'd0, 4'b1001, 1);
    consume("div_illegal");
    issue(ARITH_MOD, 16'd100, 16'd7);
    wait_result("mod_illegal", 1, 16'd0, 4'b1001, 1);
    consume("mod_illegal");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
